// File: rtl/tmr_voter_monitor.sv
// Triple-modular-redundancy voter: registers three WIDTH-bit channels, majority-votes them,
// and tracks persistent per-channel disagreement. Define TMR_DEGRADE_EN to vote around one faulty channel.

module tmr_chan_mon #(
  parameter int PERSIST = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic mis,
  input  logic hold,
  output logic fault
);
  logic [7:0] run;
  logic [7:0] run_inc;

  assign run_inc = run + 8'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run   <= '0;
      fault <= 1'b0;
    end else if (clear) begin
      run   <= '0;
      fault <= 1'b0;
    end else if (!hold) begin
      if (!mis) begin
        run <= '0;
      end else if (run != 8'(PERSIST)) begin
        run <= run_inc;
        if (run_inc == 8'(PERSIST)) fault <= 1'b1;
      end
    end
  end
endmodule

module tmr_voter_monitor #(
  parameter int WIDTH   = 8,
  parameter int PERSIST = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic             clear,
  output logic [WIDTH-1:0] voted_out,
  output logic             error,
  output logic [2:0]       fault_vec,
  output logic             multi_fault,
  output logic             uncorrectable,
  output logic [CNT_W-1:0] err_count
);
  logic [2:0][WIDTH-1:0] ch_r;
  logic [WIDTH-1:0]      maj;
  logic [WIDTH-1:0]      vote;
  logic [2:0]            mis;
  logic [2:0]            hold;
  logic                  err_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ch_r <= '0;
    else          ch_r <= {c_in, b_in, a_in};
  end

  assign maj     = (ch_r[0] & ch_r[1]) | (ch_r[1] & ch_r[2]) | (ch_r[0] & ch_r[2]);
  assign err_nxt = (ch_r[0] != ch_r[1]) | (ch_r[1] != ch_r[2]);

`ifdef TMR_DEGRADE_EN
  logic             single;
  logic             pair_ok;
  logic             unc_set;
  logic [WIDTH-1:0] pair_p;
  logic [WIDTH-1:0] pair_q;

  // Healthy pair = the two channels not flagged; valid only when exactly one flag is set.
  assign single  = (fault_vec == 3'b001) | (fault_vec == 3'b010) | (fault_vec == 3'b100);
  assign pair_p  = fault_vec[0] ? ch_r[1] : ch_r[0];
  assign pair_q  = fault_vec[2] ? ch_r[1] : ch_r[2];
  assign pair_ok = (pair_p == pair_q);

  always_comb begin
    vote    = maj;
    hold    = '0;
    unc_set = 1'b0;
    if (single) begin
      if (pair_ok) begin
        vote = pair_p;
      end else begin
        vote    = voted_out;
        hold    = ~fault_vec;
        unc_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     uncorrectable <= 1'b0;
    else if (clear)   uncorrectable <= 1'b0;
    else if (unc_set) uncorrectable <= 1'b1;
  end
`else
  assign vote          = maj;
  assign hold          = '0;
  assign uncorrectable = 1'b0;
`endif

  for (genvar i = 0; i < 3; i++) begin : g_chan
    assign mis[i] = |(ch_r[i] ^ vote);
    tmr_chan_mon #(.PERSIST(PERSIST)) u_mon (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .mis     (mis[i]),
      .hold    (hold[i]),
      .fault   (fault_vec[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      voted_out <= '0;
      error     <= 1'b0;
    end else begin
      voted_out <= vote;
      error     <= err_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        err_count <= '0;
    else if (clear)                      err_count <= '0;
    else if (err_nxt && err_count != '1) err_count <= err_count + 1'b1;
  end

  assign multi_fault = (fault_vec[0] & fault_vec[1]) | (fault_vec[1] & fault_vec[2]) |
                       (fault_vec[0] & fault_vec[2]);
endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Bench for tmr_voter_monitor: directed and random stimulus against a per-bit counting model.
module tb_tmr_voter_monitor;
  localparam int W = 8;
  localparam int P = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0, c_in = '0;
  logic         clear = 1'b0;
  logic [W-1:0] voted_out;
  logic         error;
  logic [2:0]   fault_vec;
  logic         multi_fault;
  logic         uncorrectable;
  logic [7:0]   err_count;

  int checks = 0;
  int passes = 0;

  logic [W-1:0] s1 [3];
  logic [W-1:0] m_vote;
  bit           m_err;
  int           m_run [3];
  bit           m_fault [3];
  int           m_ecnt;
  bit           m_unc;

  tmr_voter_monitor #(.WIDTH(W), .PERSIST(P), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .clear(clear), .voted_out(voted_out), .error(error), .fault_vec(fault_vec),
    .multi_fault(multi_fault), .uncorrectable(uncorrectable), .err_count(err_count)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] majority(input logic [W-1:0] x, y, z);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (int'(x[i]) + int'(y[i]) + int'(z[i])) >= 2;
    return r;
  endfunction

  function automatic int nfaults();
    int n = 0;
    for (int k = 0; k < 3; k++) n += int'(m_fault[k]);
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin s1[k] = '0; m_run[k] = 0; m_fault[k] = 0; end
    m_vote = '0; m_err = 0; m_ecnt = 0; m_unc = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] ia, ib, ic, input bit clr);
    logic [W-1:0] v;
    bit hold [3];
    bit e;
    int h [2];
    int n;
    v = majority(s1[0], s1[1], s1[2]);
    for (int k = 0; k < 3; k++) hold[k] = 0;
`ifdef TMR_DEGRADE_EN
    if (nfaults() == 1) begin
      n = 0;
      for (int k = 0; k < 3; k++) if (!m_fault[k]) begin h[n] = k; n++; end
      if (s1[h[0]] == s1[h[1]]) v = s1[h[0]];
      else begin
        v = m_vote; hold[h[0]] = 1; hold[h[1]] = 1; m_unc = 1;
      end
    end
`endif
    e = !((s1[0] == s1[1]) && (s1[1] == s1[2]));
    for (int k = 0; k < 3; k++) begin
      if (hold[k]) continue;
      if (s1[k] != v) begin
        if (m_run[k] < P) m_run[k]++;
        if (m_run[k] == P) m_fault[k] = 1;
      end else m_run[k] = 0;
    end
    if (e && m_ecnt < 255) m_ecnt++;
    if (clr) begin
      for (int k = 0; k < 3; k++) begin m_run[k] = 0; m_fault[k] = 0; end
      m_ecnt = 0; m_unc = 0;
    end
    m_vote = v; m_err = e;
    s1[0] = ia; s1[1] = ib; s1[2] = ic;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".voted_out"}, 32'(voted_out), 32'(m_vote));
    chk({tag, ".error"}, 32'(error), 32'(m_err));
    chk({tag, ".fault_vec"}, 32'(fault_vec),
        32'({m_fault[2], m_fault[1], m_fault[0]}));
    chk({tag, ".multi_fault"}, 32'(multi_fault), 32'(nfaults() >= 2));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_ecnt));
    chk({tag, ".uncorrectable"}, 32'(uncorrectable), 32'(m_unc));
  endtask

  task automatic step(input string tag, input logic [W-1:0] a, b, c, input bit clr);
    a_in = a; b_in = b; c_in = c; clear = clr;
    @(posedge clock);
    model_edge(a, b, c, clr);
    #1;
    clear = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] base, ra, rb, rc;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    #2;

    for (int i = 0; i < 3; i++) step("agree5A", 8'h5A, 8'h5A, 8'h5A, 0);
    chk("agree5A.voted_direct", 32'(voted_out), 32'h5A);
    for (int i = 0; i < 3; i++) step("cbad", 8'h5A, 8'h5A, 8'hFF, 0);
    chk("cbad.fault_below", 32'(fault_vec), 32'h0);
    for (int i = 0; i < 3; i++) step("cfault", 8'h5A, 8'h5A, 8'hFF, 0);
    chk("cfault.fault_c", 32'(fault_vec), 32'h4);
    chk("cfault.voted_direct", 32'(voted_out), 32'h5A);

    step("clr1", 8'h01, 8'h02, 8'h03, 1);
    for (int i = 0; i < 7; i++) step("ab_mis", 8'h01, 8'h02, 8'h03, 0);
    chk("ab_mis.voted_direct", 32'(voted_out), 32'h03);
    chk("ab_mis.fault_ab", 32'(fault_vec), 32'h3);
    chk("ab_mis.multi", 32'(multi_fault), 32'h1);

    for (int i = 0; i < 260; i++) step("sat", 8'h01, 8'h02, 8'h03, 0);
    chk("sat.err_count_ff", 32'(err_count), 32'hFF);
    step("clr_err", 8'h01, 8'h02, 8'h03, 1);
    chk("clr_err.err_count", 32'(err_count), 32'h0);
    chk("clr_err.fault", 32'(fault_vec), 32'h0);

    for (int i = 0; i < 60; i++) begin
      base = W'($urandom);
      ra = base; rb = base; rc = base;
      if ($urandom_range(3) == 0) ra ^= W'(1 << $urandom_range(W - 1));
      if ($urandom_range(3) == 0) rb ^= W'(1 << $urandom_range(W - 1));
      if ($urandom_range(2) == 0) rc ^= W'($urandom_range(255, 1));
      step("rand", ra, rb, rc, $urandom_range(15) == 0);
    end

    step("clr2", 8'h11, 8'h11, 8'hFF, 1);
    for (int i = 0; i < 6; i++) step("degr_setup", 8'h11, 8'h11, 8'hFF, 0);
    for (int i = 0; i < 4; i++) step("degr_split", 8'h11, 8'h22, 8'hFF, 0);
    for (int i = 0; i < 4; i++) step("degr_heal", 8'h44, 8'h44, 8'h00, 0);

    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 reset_n = 1'b1;
    step("post_rst1", 8'hC3, 8'hC3, 8'hC3, 0);
    chk("post_rst1.voted_zero", 32'(voted_out), 32'h0);
    step("post_rst2", 8'hC3, 8'hC3, 8'hC3, 0);
    chk("post_rst2.voted_data", 32'(voted_out), 32'hC3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
